btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  N-channel button conditioner for all board push-buttons (start, pause, menu, ...) in the game top.
//  Per channel: synchronises the raw pin and debounces it with a stable-time counter.
//  Emits a clean level, press/release pulses, a one-shot long-press pulse and optional auto-repeat.
//  Runs in the sys_clk (25 MHz) game domain; replaces the single-channel rising-edge debouncer.
// PARAMETERS
//  N_BTN         4           number of independent channels
//  SYNC_STAGES   2           synchroniser flops per channel (>=2)
//  DB_CYCLES     250_000     consecutive cycles an input change must persist (10 ms @25 MHz, >=2)
//  LONG_CYCLES   25_000_000  hold time after press before o_long fires (1 s, >=1)
//  REPEAT_CYCLES 2_500_000   auto-repeat period once long-held (100 ms, >=1)
//  ACTIVE_LOW    '0          N_BTN bitmask; bit=1 -> pin is pressed when 0 (inverted after sync)
// PORTS
//  clk          in   1      sys_clk; one clock, all logic on posedge clk
//  reset        in   1      asynchronous, active-high
//  i_btn        in   N_BTN  raw asynchronous button pins
//  i_repeat_en  in   N_BTN  per-channel auto-repeat enable, sampled every cycle
//  o_level      out  N_BTN  debounced pressed level (1 = pressed)
//  o_press      out  N_BTN  1-cycle pulse: debounced press, plus each auto-repeat tick
//  o_release    out  N_BTN  1-cycle pulse: debounced release
//  o_long       out  N_BTN  1-cycle pulse, once per press, when held LONG_CYCLES
// BEHAVIOUR
//  - Reset: every sync flop, counter and output = 0; hold FSM = RELEASED.
//    Asserting reset mid-press drops o_level immediately, without an o_release pulse.
//  - Sync: raw pin passes SYNC_STAGES flops, then ACTIVE_LOW inversion gives s.
//  - Debounce: db_cnt clears whenever s == o_level, else increments.
//    On the cycle db_cnt == DB_CYCLES-1 with mismatch still present, o_level <= s and db_cnt <= 0.
//    Any mismatch shorter than DB_CYCLES cycles produces no output change.
//  - Latency: pin edge -> o_level change = SYNC_STAGES + DB_CYCLES cycles.
//  - o_press / o_release are registered and high in the same cycle o_level first takes its new value.
//  - Hold FSM per channel (shared enum hold_state_t):
//      RELEASED: o_level rise -> HELD, hold_cnt <= 0.
//      HELD: hold_cnt++ each cycle. At hold_cnt == LONG_CYCLES-1: o_long pulse, -> LONG, rep_cnt <= 0.
//      LONG: if i_repeat_en, rep_cnt++. At rep_cnt == REPEAT_CYCLES-1: o_press pulse, rep_cnt <= 0.
//            While i_repeat_en == 0: rep_cnt held at 0 and no pulses (repeat stops the same cycle).
//      Any state: o_level fall -> RELEASED, counters cleared, no long/repeat pulse that cycle.
//      Release takes priority over a coincident long or repeat expiry.
//  - o_long fires at most once per press. Counters never wrap: LONG stays until release.
//  - Counter widths: $clog2(X_CYCLES+1). All arithmetic unsigned.
//  - Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
// STRUCTURE
//  - Package btn_pkg: hold_state_t {RELEASED, HELD, LONG}; cycle-count constants for 25 MHz (10 ms, 1 s, 100 ms).
//  - Sub-module btn_debounce_ch: one channel (sync, debounce, FSM).
//    Top instantiates N_BTN copies in a generate loop, with the ACTIVE_LOW bit passed per instance.
// TESTING  (bench params: N_BTN=2, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
//  1. Glitch: i_btn[0] high for 3 cycles -> no activity on any output.
//     High for 10 cycles -> o_press[0] pulse and o_level[0] rise 6 cycles after the pin edge.
//  2. Bounce: toggle every 2 cycles for 20 cycles, then hold high.
//     -> exactly one o_press, 6 cycles after the last edge.
//  3. Long + repeat: i_repeat_en[0]=1, hold 60 cycles after o_press.
//     -> o_long at press+20; o_press at press+25, +30, +35, ... ; o_long never repeats.
//  4. Repeat gate: same as 3, but i_repeat_en[0] drops at press+27 -> no o_press after press+25.
//     Release during LONG -> o_release 6 cycles after the pin falls.
//  5. Active-low/parallel: ACTIVE_LOW=2'b10. Pin1 driven low and pin0 high on the same cycle.
//     -> o_press=2'b11 in one cycle. o_level[1] idles 0 while pin1 is high.
//  6. Reset mid-hold (state LONG) -> all outputs 0 next cycle, no o_release.
//     After release of reset with pin still pressed -> fresh o_press 6 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and 25 MHz timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        LONG     = 2'd2
    } hold_state_t;

    localparam int unsigned DB_CYCLES_25M     = 250_000;     // 10 ms
    localparam int unsigned LONG_CYCLES_25M   = 25_000_000;  // 1 s
    localparam int unsigned REPEAT_CYCLES_25M = 2_500_000;   // 100 ms

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stable-time debouncer and long-press / auto-repeat FSM.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = DB_CYCLES_25M,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_25M,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_25M,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic [LONG_W-1:0]      r_hold_cnt;
    logic [REP_W-1:0]       r_rep_cnt;
    hold_state_t            r_state;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;

    logic w_s;
    logic w_commit;
    logic w_rise;
    logic w_fall;

    assign w_s      = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign w_commit = (w_s != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise   = w_commit && w_s;
    assign w_fall   = w_commit && !w_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync     <= '0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_state    <= RELEASED;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            if (w_s == r_level) begin
                r_db_cnt <= '0;
            end else if (w_commit) begin
                r_db_cnt  <= '0;
                r_level   <= w_s;
                r_press   <= w_s;
                r_release <= !w_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            // A release overrides any long/repeat expiry landing on the same cycle.
            if (w_fall) begin
                r_state    <= RELEASED;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
            end else begin
                case (r_state)
                    RELEASED: begin
                        if (w_rise) begin
                            r_state    <= HELD;
                            r_hold_cnt <= '0;
                        end
                    end
                    HELD: begin
                        if (r_hold_cnt == LONG_LAST) begin
                            r_long    <= 1'b1;
                            r_state   <= LONG;
                            r_rep_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!i_repeat_en) begin
                            r_rep_cnt <= '0;
                        end else if (r_rep_cnt == REP_LAST) begin
                            r_press   <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    default: r_state <= RELEASED;
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent button channels, each with its own pin polarity.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int unsigned      N_BTN         = 4,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter int unsigned      DB_CYCLES     = DB_CYCLES_25M,
    parameter int unsigned      LONG_CYCLES   = LONG_CYCLES_25M,
    parameter int unsigned      REPEAT_CYCLES = REPEAT_CYCLES_25M,
    parameter logic [N_BTN-1:0] ACTIVE_LOW    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_BTN-1:0] i_repeat_en,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW[g])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_btn       (i_btn[g]),
            .i_repeat_en (i_repeat_en[g]),
            .o_level     (o_level[g]),
            .o_press     (o_press[g]),
            .o_release   (o_release[g]),
            .o_long      (o_long[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench: glitch, bounce, long/repeat, repeat gating, active-low parallel, reset mid-hold.
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] i_btn;
    logic [1:0] i_repeat_en;
    logic [1:0] o_level;
    logic [1:0] o_press;
    logic [1:0] o_release;
    logic [1:0] o_long;

    int         checks = 0;
    int         errors = 0;
    int         n_press0 = 0;
    logic [1:0] any_press;
    logic [1:0] any_rel;
    logic [1:0] any_long;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_BTN         (2),
        .SYNC_STAGES   (2),
        .DB_CYCLES     (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (5),
        .ACTIVE_LOW    (2'b10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn       (i_btn),
        .i_repeat_en (i_repeat_en),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_long      (o_long)
    );

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_press0  = 0;
        any_press = 2'b00;
        any_rel   = 2'b00;
        any_long  = 2'b00;
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_press[0]) n_press0++;
        any_press = any_press | o_press;
        any_rel   = any_rel | o_release;
        any_long  = any_long | o_long;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset       = 1'b1;
        i_btn       = 2'b10;
        i_repeat_en = 2'b00;
        clr();
        ticks(2);
        check("rst_level", o_level, 2'b00);
        check("rst_press", o_press, 2'b00);
        check("rst_release", o_release, 2'b00);
        check("rst_long", o_long, 2'b00);
        reset = 1'b0;
        ticks(8);

        // 1. Glitch shorter than the debounce window, then a real press.
        clr();
        i_btn[0] = 1'b1;
        ticks(3);
        i_btn[0] = 1'b0;
        ticks(10);
        check("glitch_press", any_press, 2'b00);
        check("glitch_rel", any_rel, 2'b00);
        check("glitch_long", any_long, 2'b00);
        check("glitch_level", o_level, 2'b00);
        i_btn[0] = 1'b1;
        ticks(5);
        check("t1_level_early", o_level, 2'b00);
        check("t1_press_early", any_press, 2'b00);
        tick();
        check("t1_press", o_press, 2'b01);
        check("t1_level", o_level, 2'b01);
        tick();
        check("t1_press_1shot", o_press, 2'b00);
        ticks(3);
        i_btn[0] = 1'b0;
        ticks(5);
        check("t1_level_hold", o_level, 2'b01);
        tick();
        check("t1_release", o_release, 2'b01);
        check("t1_level_fall", o_level, 2'b00);
        tick();
        check("t1_release_1shot", o_release, 2'b00);
        check("t1_no_long", any_long, 2'b00);
        ticks(10);

        // 2. Bounce: toggle every 2 cycles, then hold high.
        clr();
        for (int i = 0; i < 10; i++) begin
            i_btn[0] = ~i_btn[0];
            ticks(2);
        end
        i_btn[0] = 1'b1;
        ticks(5);
        check("t2_no_early_press", any_press, 2'b00);
        check("t2_level_early", o_level, 2'b00);
        tick();
        check("t2_press", o_press, 2'b01);
        ticks(2);
        i_btn[0] = 1'b0;
        ticks(6);
        check("t2_release", o_release, 2'b01);
        checks++;
        assert (n_press0 == 1) else begin
            errors++;
            $error("FAIL t2_press_count got %0d exp 1", n_press0);
        end
        ticks(10);

        // 3. Long press with auto-repeat, released while LONG.
        i_repeat_en = 2'b01;
        i_btn[0] = 1'b1;
        ticks(6);
        check("t3_press0", o_press, 2'b01);
        for (int k = 1; k <= 70; k++) begin
            tick();
            check($sformatf("t3_press_k%0d", k), o_press,
                  {1'b0, (k >= 25 && k < 66 && (k - 25) % 5 == 0)});
            check($sformatf("t3_long_k%0d", k), o_long, {1'b0, k == 20});
            check($sformatf("t3_rel_k%0d", k), o_release, {1'b0, k == 66});
            if (k == 60) i_btn[0] = 1'b0;
        end
        ticks(5);

        // 4. Repeat enable dropped after the first repeat tick.
        i_btn[0] = 1'b1;
        ticks(6);
        check("t4_press0", o_press, 2'b01);
        for (int k = 1; k <= 50; k++) begin
            tick();
            check($sformatf("t4_press_k%0d", k), o_press, {1'b0, k == 25});
            check($sformatf("t4_long_k%0d", k), o_long, {1'b0, k == 20});
            check($sformatf("t4_rel_k%0d", k), o_release, {1'b0, k == 46});
            if (k == 26) i_repeat_en = 2'b00;
            if (k == 40) i_btn[0] = 1'b0;
        end
        ticks(5);

        // 5. Active-low pin1 and active-high pin0 pressed together.
        i_btn = 2'b01;
        ticks(5);
        check("t5_level_early", o_level, 2'b00);
        tick();
        check("t5_press", o_press, 2'b11);
        check("t5_level", o_level, 2'b11);
        i_btn = 2'b10;
        ticks(6);
        check("t5_release", o_release, 2'b11);
        check("t5_level_fall", o_level, 2'b00);
        ticks(5);

        // 6. Reset while in LONG, pin kept pressed.
        clr();
        i_btn[0] = 1'b1;
        ticks(6);
        check("t6_press", o_press, 2'b01);
        ticks(22);
        check("t6_long_seen", any_long, 2'b01);
        check("t6_level_pre", o_level, 2'b01);
        clr();
        reset = 1'b1;
        tick();
        check("t6_rst_level", o_level, 2'b00);
        check("t6_rst_press", o_press, 2'b00);
        check("t6_rst_long", o_long, 2'b00);
        tick();
        reset = 1'b0;
        ticks(5);
        check("t6_level_early", o_level, 2'b00);
        tick();
        check("t6_fresh_press", o_press, 2'b01);
        check("t6_fresh_level", o_level, 2'b01);
        check("t6_no_release", any_rel, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
